control_sequencer: RTL and testbench
====================================

# control_sequencer

Microprogram sequencer for the control unit. It holds the current control state and computes the next one each cycle from the microstore's next-state select, the memory-operation-complete handshake, the condition tester result, and the encoder's 10-bit `state_number`. It sits directly downstream of the instruction encoder and drives the microstore address, which is the current state number.

## Interface

Parameters:
- `FETCH_STATE`, default 10'd1: first state of the fetch microroutine.
- `EXEC_MIN`, default 10'd20: lowest legal dispatch target.
- `EXEC_MAX`, default 10'd39: highest legal dispatch target.
- `TIMEOUT_CYCLES`, default 15: consecutive wait cycles before a bus error. Legal range is 1..15. Only meaningful with `SEQ_MOC_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `state_number` in 10: dispatch target from the encoder.
- `nsel` in 2: next-state select from the microstore. 00 INC, 01 DISPATCH, 10 JUMP, 11 WAIT.
- `cr_addr` in 10: jump target from the microstore.
- `cond_pass` in 1: condition tester result, sampled only on DISPATCH.
- `moc` in 1: memory operation complete.
- `state` out 10: current state, registered; also the microstore address.
- `mem_stall` out 1: combinational, equals `nsel==WAIT && !moc`.
- `illegal` out 1: registered one-cycle pulse on a rejected dispatch.
- `bus_err` out 1: registered one-cycle pulse on a wait timeout.
- `instr_cnt` out 16: count of accepted dispatches, registered, wraps.

## Operation

- **Reset:** `reset_n`=0 immediately forces `state`=0, `illegal`=0, `bus_err`=0, `instr_cnt`=0 and the wait counter=0, with no clock required.
- **State 0:** next state is `FETCH_STATE` unconditionally; `nsel` is ignored.
- **INC:** next state is `state`+1, modulo 1024. From 1023 it wraps to 0, which then goes to `FETCH_STATE`.
- **DISPATCH:**
  - `cond_pass`=0 gives next state `FETCH_STATE`. This is not illegal and does not count.
  - `cond_pass`=1 with `EXEC_MIN` ≤ `state_number` ≤ `EXEC_MAX` gives next state `state_number` and increments `instr_cnt`.
  - `cond_pass`=1 with `state_number` outside that range gives next state `FETCH_STATE`, pulses `illegal`, and does not count.
  - Range checks are unsigned and inclusive.
- **JUMP:** next state is `cr_addr`, with no range check.
- **WAIT:**
  - With `moc`=1, next state is `state`+1 and the wait counter clears.
  - With `moc`=0, `state` holds and the wait counter increments, saturating at 15.
- **Wait counter:** clears on any cycle where `nsel`≠WAIT.
- **`instr_cnt`:** wraps from 16'hFFFF to 0.

## Timing

- All state changes happen on the rising edge of `clk`.
- Inputs are sampled at the edge that ends the cycle in which `state` presents the corresponding microword.
- Dispatch latency is 1 cycle: `state_number` sampled at edge N appears on `state` after edge N.
- The encoder output must be stable during any cycle whose microword is DISPATCH.
- The `illegal` and `bus_err` pulses are asserted for the cycle after the triggering edge, coincident with `state`=`FETCH_STATE`.
- `mem_stall` follows `moc` and `nsel` in the same cycle.
- If `moc` rises on the same edge the timeout would fire, `moc` wins: the sequencer advances and does not pulse `bus_err`.
- An asynchronous reset during WAIT aborts the wait; no `bus_err` pulse is produced.

## Configuration

`SEQ_MOC_TIMEOUT_EN`:
- **Defined:** in WAIT, if the wait counter reaches `TIMEOUT_CYCLES` and `moc`=0 at the edge, the next state is `FETCH_STATE`, `bus_err` pulses, and the counter clears.
- **Undefined:**
  - WAIT holds indefinitely until `moc`.
  - `bus_err` is tied to 0.
  - The wait counter is not instantiated.

## Test plan

- **Reset and fetch:** hold `reset_n` low, then release it with `nsel`=INC. Expected: `state`=0, then 1, then 2; `instr_cnt`=0.
- **Legal dispatch:** `nsel`=DISPATCH, `cond_pass`=1, `state_number`=10'd22. Expected: `state`=22 the next cycle, `instr_cnt`=1, `illegal`=0.
- **Condition fail and illegal dispatch:**
  - DISPATCH with `cond_pass`=0 and `state_number`=20 gives `state`=1, no count, no `illegal`.
  - DISPATCH with `cond_pass`=1 and `state_number`=10'd5 gives `state`=1 and a one-cycle `illegal` pulse.
- **WAIT handshake:** in state 25 with `nsel`=WAIT, hold `moc`=0 for 3 cycles, then drive `moc`=1. Expected: `state` stays 25 with `mem_stall`=1 for 3 cycles, then goes to 26.
- **Timeout (with `SEQ_MOC_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):**
  - Holding `moc`=0 gives `bus_err` for one cycle and `state`=1 after the 5th edge.
  - Repeating with `moc`=1 on that edge advances to `state`+1 with no `bus_err`.
- **Reset mid-wait and wrap-around:**
  - Asserting `reset_n` low mid-edge during WAIT gives `state`=0 immediately.
  - JUMP to 1023 followed by INC gives 0, then 1.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Microprogram sequencer for the control unit. Holds the current control state
// (which doubles as the microstore address) and selects the next one each
// cycle from the microword's next-state select, the memory handshake, the
// condition tester and the instruction encoder's dispatch target.
//
// Optional feature macro: SEQ_MOC_TIMEOUT_EN
//   defined   - a WAIT that sees no moc for TIMEOUT_CYCLES consecutive cycles
//               aborts to FETCH_STATE and pulses bus_err.
//   undefined - WAIT holds until moc; bus_err is tied low and no wait counter
//               exists.
//
// Parameters:
//   FETCH_STATE     first state of the fetch microroutine
//   EXEC_MIN        lowest legal dispatch target (inclusive, unsigned)
//   EXEC_MAX        highest legal dispatch target (inclusive, unsigned)
//   TIMEOUT_CYCLES  wait cycles tolerated before a bus error (1..15)
//
// Ports:
//   clk           in   1  rising-edge clock
//   reset_n       in   1  asynchronous active-low reset
//   state_number  in  10  dispatch target from the encoder
//   nsel          in   2  next-state select: 00 INC, 01 DISPATCH, 10 JUMP,
//                         11 WAIT
//   cr_addr       in  10  jump target from the microstore
//   cond_pass     in   1  condition tester result (used on DISPATCH only)
//   moc           in   1  memory operation complete
//   state         out 10  current state / microstore address (registered)
//   mem_stall     out  1  combinational: nsel==WAIT && !moc
//   illegal       out  1  registered pulse on a rejected dispatch
//   bus_err       out  1  registered pulse on a wait timeout
//   instr_cnt     out 16  accepted dispatch count, wraps (registered)
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter logic [9:0]  FETCH_STATE    = 10'd1,
  parameter logic [9:0]  EXEC_MIN       = 10'd20,
  parameter logic [9:0]  EXEC_MAX       = 10'd39,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  state_number,
  input  logic [1:0]  nsel,
  input  logic [9:0]  cr_addr,
  input  logic        cond_pass,
  input  logic        moc,
  output logic [9:0]  state,
  output logic        mem_stall,
  output logic        illegal,
  output logic        bus_err,
  output logic [15:0] instr_cnt
);

  typedef enum logic [1:0] {
    NSEL_INC      = 2'b00,
    NSEL_DISPATCH = 2'b01,
    NSEL_JUMP     = 2'b10,
    NSEL_WAIT     = 2'b11
  } nsel_e;

  nsel_e sel;
  assign sel = nsel_e'(nsel);

  // Registered state and its next-state values.
  logic [9:0]  state_q,     state_d;
  logic        illegal_q,   illegal_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;

  // Qualifiers used by the next-state logic.
  logic        in_state_zero;
  logic        dispatch_in_range;
  logic        waiting;          // WAIT microword with memory not yet done

  assign in_state_zero     = (state_q == 10'd0);
  assign dispatch_in_range = (state_number >= EXEC_MIN) && (state_number <= EXEC_MAX);
  assign waiting           = !in_state_zero && (sel == NSEL_WAIT) && !moc;

  // The stall flag is a pure function of the current microword and handshake,
  // so the datapath can freeze in the same cycle.
  assign mem_stall = (sel == NSEL_WAIT) && !moc;

`ifdef SEQ_MOC_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LIMIT = 4'(TIMEOUT_CYCLES);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       bus_err_q,  bus_err_d;
  logic       timeout_hit;

  // The counter value tested here is the count of wait cycles already spent,
  // so the abort happens on the edge after TIMEOUT_CYCLES stalled cycles. A
  // moc on that edge clears `waiting` and therefore wins over the timeout.
  assign timeout_hit = waiting && (wait_cnt_q >= TIMEOUT_LIMIT);

  always_comb begin
    wait_cnt_d = 4'd0;
    bus_err_d  = timeout_hit;
    if (waiting && !timeout_hit) begin
      wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Next-state selection.
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    illegal_d   = 1'b0;
    instr_cnt_d = instr_cnt_q;

    if (in_state_zero) begin
      // State 0 is the post-reset / post-wrap landing state; the microword
      // there is not trusted, so always enter fetch.
      state_d = FETCH_STATE;
    end else begin
      unique case (sel)
        NSEL_INC: begin
          state_d = state_q + 10'd1;     // 10-bit add wraps 1023 -> 0
        end
        NSEL_DISPATCH: begin
          if (!cond_pass) begin
            state_d = FETCH_STATE;
          end else if (dispatch_in_range) begin
            state_d     = state_number;
            instr_cnt_d = instr_cnt_q + 16'd1;
          end else begin
            state_d   = FETCH_STATE;
            illegal_d = 1'b1;
          end
        end
        NSEL_JUMP: begin
          state_d = cr_addr;
        end
        NSEL_WAIT: begin
          if (moc) begin
            state_d = state_q + 10'd1;
          end
`ifdef SEQ_MOC_TIMEOUT_EN
          else if (timeout_hit) begin
            state_d = FETCH_STATE;
          end
`endif
          else begin
            state_d = state_q;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= 10'd0;
      illegal_q   <= 1'b0;
      instr_cnt_q <= 16'd0;
`ifdef SEQ_MOC_TIMEOUT_EN
      wait_cnt_q  <= 4'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      instr_cnt_q <= instr_cnt_d;
`ifdef SEQ_MOC_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign state     = state_q;
  assign illegal   = illegal_q;
  assign instr_cnt = instr_cnt_q;

`ifndef SYNTHESIS
  // Both error pulses coincide with the sequencer landing in fetch.
  a_illegal_to_fetch : assert property (@(posedge clk) disable iff (!reset_n)
    illegal |-> (state == FETCH_STATE));
  a_bus_err_to_fetch : assert property (@(posedge clk) disable iff (!reset_n)
    bus_err |-> (state == FETCH_STATE));
  a_timeout_range : assert property (@(posedge clk)
    (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 15));
`endif

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam logic [9:0] FETCH = 10'd1;
  localparam int         XMIN  = 20;
  localparam int         XMAX  = 39;
  localparam int         TMO   = 4;

  localparam logic [1:0] INC  = 2'b00;
  localparam logic [1:0] DISP = 2'b01;
  localparam logic [1:0] JMP  = 2'b10;
  localparam logic [1:0] WT   = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  state_number;
  logic [1:0]  nsel;
  logic [9:0]  cr_addr;
  logic        cond_pass;
  logic        moc;
  logic [9:0]  state;
  logic        mem_stall;
  logic        illegal;
  logic        bus_err;
  logic [15:0] instr_cnt;

  control_sequencer #(
    .FETCH_STATE   (FETCH),
    .EXEC_MIN      (10'd20),
    .EXEC_MAX      (10'd39),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .state_number(state_number),
    .nsel        (nsel),
    .cr_addr     (cr_addr),
    .cond_pass   (cond_pass),
    .moc         (moc),
    .state       (state),
    .mem_stall   (mem_stall),
    .illegal     (illegal),
    .bus_err     (bus_err),
    .instr_cnt   (instr_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs after the edge that consumes one cycle's inputs, plus the
  // stall flag that those inputs should have produced during the cycle.
  typedef struct {
    int state;
    int illegal;
    int bus_err;
    int cnt;
    int stall;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: plain integers derived from the behaviour rules.
  int m_state = 0;
  int m_cnt   = 0;
  int m_wait  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_wait  = 0;
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the model
  // says the following rising edge must produce.
  task automatic step(input logic rst, input logic [1:0] ns, input int sn,
                      input int cr, input logic cp, input logic mc);
    exp_t e;
    int   nxt;
    @(negedge clk);
    reset_n      = rst;
    nsel         = ns;
    state_number = sn[9:0];
    cr_addr      = cr[9:0];
    cond_pass    = cp;
    moc          = mc;

    e.stall   = (ns == WT && !mc) ? 1 : 0;
    e.illegal = 0;
    e.bus_err = 0;
    if (!rst) begin
      model_reset();
    end else begin
      nxt = m_state;
      if (m_state == 0) begin
        nxt    = FETCH;
        m_wait = 0;
      end else begin
        case (ns)
          INC: begin
            nxt    = (m_state + 1) % 1024;
            m_wait = 0;
          end
          DISP: begin
            m_wait = 0;
            if (!cp) nxt = FETCH;
            else if (sn >= XMIN && sn <= XMAX) begin
              nxt   = sn;
              m_cnt = (m_cnt + 1) % 65536;
            end else begin
              nxt       = FETCH;
              e.illegal = 1;
            end
          end
          JMP: begin
            nxt    = cr;
            m_wait = 0;
          end
          default: begin
            if (mc) begin
              nxt    = (m_state + 1) % 1024;
              m_wait = 0;
            end else begin
`ifdef SEQ_MOC_TIMEOUT_EN
              if (m_wait >= TMO) begin
                nxt       = FETCH;
                e.bus_err = 1;
                m_wait    = 0;
              end else begin
                m_wait = (m_wait < 15) ? m_wait + 1 : 15;
              end
`endif
            end
          end
        endcase
      end
      m_state = nxt;
    end
    e.state = m_state;
    e.cnt   = m_cnt;
    sb.push_back(e);
  endtask

  // Wait until the edge after the last step has settled.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every rising edge that consumed a queued cycle is compared.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("state",     int'(state),     e.state);
        check("illegal",   int'(illegal),   e.illegal);
        check("bus_err",   int'(bus_err),   e.bus_err);
        check("instr_cnt", int'(instr_cnt), e.cnt);
        check("mem_stall", int'(mem_stall), e.stall);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int r;
    reset_n      = 1'b0;
    nsel         = INC;
    state_number = 10'd0;
    cr_addr      = 10'd0;
    cond_pass    = 1'b0;
    moc          = 1'b0;
    #2;
    check("reset_state", int'(state), 0);
    check("reset_cnt",   int'(instr_cnt), 0);
    check("reset_ill",   int'(illegal), 0);

    // Reset and fetch: release with INC, expect 0 -> 1 -> 2.
    step(1'b0, INC, 0, 0, 1'b0, 1'b1);
    step(1'b1, INC, 0, 0, 1'b0, 1'b1);
    step(1'b1, INC, 0, 0, 1'b0, 1'b1);
    settle();
    check("fetch_seq_state", int'(state), 2);

    // Legal dispatch to 22.
    step(1'b1, DISP, 22, 0, 1'b1, 1'b1);
    settle();
    check("disp_legal_state", int'(state), 22);
    check("disp_legal_cnt",   int'(instr_cnt), 1);

    // Condition fail, then an out-of-range dispatch.
    step(1'b1, DISP, 20, 0, 1'b0, 1'b1);
    settle();
    check("disp_cfail_state", int'(state), 1);
    step(1'b1, JMP, 0, 30, 1'b0, 1'b1);
    step(1'b1, DISP, 5, 0, 1'b1, 1'b1);
    settle();
    check("disp_illegal_state", int'(state), 1);
    check("disp_illegal_pulse", int'(illegal), 1);
    step(1'b1, INC, 0, 0, 1'b0, 1'b1);
    settle();
    check("illegal_one_cycle", int'(illegal), 0);

    // Range boundaries.
    step(1'b1, DISP, 39, 0, 1'b1, 1'b1);
    step(1'b1, DISP, 40, 0, 1'b1, 1'b1);
    step(1'b1, DISP, 20, 0, 1'b1, 1'b1);
    step(1'b1, DISP, 19, 0, 1'b1, 1'b1);
    settle();
    check("boundary_cnt", int'(instr_cnt), 3);

    // WAIT handshake in state 25.
    step(1'b1, JMP, 0, 25, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, WT, 0, 0, 1'b0, 1'b0);
    settle();
    check("wait_hold_state", int'(state), 25);
    step(1'b1, WT, 0, 0, 1'b0, 1'b1);
    settle();
    check("wait_release_state", int'(state), 26);

`ifdef SEQ_MOC_TIMEOUT_EN
    // Timeout fires on the 5th stalled edge.
    step(1'b1, JMP, 0, 25, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, WT, 0, 0, 1'b0, 1'b0);
    settle();
    check("timeout_state",   int'(state), 1);
    check("timeout_bus_err", int'(bus_err), 1);
    // moc on the would-be timeout edge wins.
    step(1'b1, JMP, 0, 25, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, WT, 0, 0, 1'b0, 1'b0);
    step(1'b1, WT, 0, 0, 1'b0, 1'b1);
    settle();
    check("moc_wins_state",   int'(state), 26);
    check("moc_wins_bus_err", int'(bus_err), 0);
`endif

    // Asynchronous reset in the middle of a wait.
    step(1'b1, JMP, 0, 25, 1'b0, 1'b1);
    step(1'b1, WT, 0, 0, 1'b0, 1'b0);
    step(1'b1, WT, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_state",   int'(state), 0);
    check("async_reset_cnt",     int'(instr_cnt), 0);
    check("async_reset_bus_err", int'(bus_err), 0);
    step(1'b0, WT, 0, 0, 1'b0, 1'b0);
    step(1'b1, INC, 0, 0, 1'b0, 1'b1);

    // Wrap-around: 1023 -> 0 -> FETCH.
    step(1'b1, JMP, 0, 1023, 1'b0, 1'b1);
    step(1'b1, INC, 0, 0, 1'b0, 1'b1);
    settle();
    check("wrap_zero", int'(state), 0);
    step(1'b1, JMP, 0, 500, 1'b0, 1'b1);
    settle();
    check("wrap_fetch", int'(state), 1);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] ns;
      int         sn;
      int         cr;
      r  = $urandom_range(0, 9);
      ns = (r < 4) ? INC : (r < 6) ? DISP : (r < 7) ? JMP : WT;
      sn = $urandom_range(0, 63);
      cr = ($urandom_range(0, 3) == 0) ? 1023 : $urandom_range(0, 1023);
      step(($urandom_range(0, 499) != 0), ns, sn, cr,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end

    settle();
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
